// File: rtl/multicycle_ctrl_wait_if.sv
// Control/datapath bundle for the multicycle RV32I controller: opcode and
// memory handshake in, datapath controls and trap/retire status out.
interface multicycle_ctrl_wait_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       instruction_opcode;
  logic             mem_ready;
  logic             pc_write, ir_write, pc_source, reg_write, memory_read;
  logic             is_immediate, memory_write, pc_write_cond, lorD, memory_to_reg;
  logic [1:0]       aluop, alu_src_a, alu_src_b;
  logic             halted;
  logic [1:0]       trap_cause;
  logic             retired;
  logic [CNT_W-1:0] instret;

  modport master (
    input  instruction_opcode, mem_ready,
    output pc_write, ir_write, pc_source, reg_write, memory_read,
           is_immediate, memory_write, pc_write_cond, lorD, memory_to_reg,
           aluop, alu_src_a, alu_src_b, halted, trap_cause, retired, instret
  );

  modport slave (
    output instruction_opcode, mem_ready,
    input  pc_write, ir_write, pc_source, reg_write, memory_read,
           is_immediate, memory_write, pc_write_cond, lorD, memory_to_reg,
           aluop, alu_src_a, alu_src_b, halted, trap_cause, retired, instret
  );
endinterface

// File: rtl/multicycle_ctrl_wait.sv
// Multicycle RV32I control FSM with memory wait states, wait-state timeout,
// sticky trap state and retired-instruction counter.
module multicycle_ctrl_wait #(
  parameter int MEM_TIMEOUT   = 16,
  parameter int CNT_W         = 32,
  parameter int SUPPORT_UPPER = 1
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_ctrl_wait_if.master bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef enum logic [4:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB,
    BRANCH, JAL_CALC, JAL_WB, JALR_CALC, JALR_WB, AUIPC_CALC, AUIPC_WB,
    LUI_CALC, LUI_WB, TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] wait_q, wait_d, wait_inc;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             in_mem, timeout;

  logic       pc_write_c, ir_write_c, pc_source_c, reg_write_c, memory_read_c;
  logic       is_immediate_c, memory_write_c, pc_write_cond_c, lord_c, mem_to_reg_c;
  logic [1:0] aluop_c, src_a_c, src_b_c;
  logic       halted_c, retired_c;

  always_comb begin
    state_d         = state_q;
    cause_d         = cause_q;
    pc_write_c      = 1'b0;
    ir_write_c      = 1'b0;
    pc_source_c     = 1'b0;
    reg_write_c     = 1'b0;
    memory_read_c   = 1'b0;
    is_immediate_c  = 1'b0;
    memory_write_c  = 1'b0;
    pc_write_cond_c = 1'b0;
    lord_c          = 1'b0;
    mem_to_reg_c    = 1'b0;
    aluop_c         = 2'b00;
    src_a_c         = 2'b00;
    src_b_c         = 2'b00;
    halted_c        = 1'b0;
    retired_c       = 1'b0;

    // Saturating wait counter; any ready cycle or non-memory state clears it.
    in_mem   = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    wait_inc = (wait_q == '1) ? wait_q : wait_q + CNT_W'(1);
    wait_d   = (in_mem && !bus.mem_ready) ? wait_inc : '0;
    timeout  = (MEM_TIMEOUT != 0) && in_mem && !bus.mem_ready &&
               (wait_inc >= CNT_W'(MEM_TIMEOUT));

    case (state_q)
      FETCH: begin
        memory_read_c = 1'b1;
        src_b_c       = 2'b01;
        ir_write_c    = bus.mem_ready;
        pc_write_c    = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        src_a_c = 2'b10;
        src_b_c = 2'b10;
        case (bus.instruction_opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECUTER;
          OP_I:              state_d = EXECUTEI;
          OP_BR:             state_d = BRANCH;
          OP_JAL:            state_d = JAL_CALC;
          OP_JALR:           state_d = JALR_CALC;
          OP_AUIPC: begin
            state_d = (SUPPORT_UPPER != 0) ? AUIPC_CALC : TRAP;
            if (SUPPORT_UPPER == 0) cause_d = 2'b01;
          end
          OP_LUI: begin
            state_d = (SUPPORT_UPPER != 0) ? LUI_CALC : TRAP;
            if (SUPPORT_UPPER == 0) cause_d = 2'b01;
          end
          OP_SYS: begin
            state_d = TRAP;
            cause_d = 2'b10;
          end
          default: begin
            state_d = TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      MEMADR: begin
        src_a_c = 2'b01;
        src_b_c = 2'b10;
        state_d = (bus.instruction_opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        memory_read_c = 1'b1;
        lord_c        = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        retired_c    = 1'b1;
        state_d      = FETCH;
      end
      MEMWRITE: begin
        memory_write_c = 1'b1;
        lord_c         = 1'b1;
        if (bus.mem_ready) begin
          retired_c = 1'b1;
          state_d   = FETCH;
        end
      end
      EXECUTER: begin
        src_a_c = 2'b01;
        aluop_c = 2'b10;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        src_a_c        = 2'b01;
        src_b_c        = 2'b10;
        aluop_c        = 2'b10;
        is_immediate_c = 1'b1;
        state_d        = ALUWB;
      end
      BRANCH: begin
        src_a_c         = 2'b01;
        aluop_c         = 2'b01;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 1'b1;
        retired_c       = 1'b1;
        state_d         = FETCH;
      end
      JAL_CALC, JALR_CALC: begin
        src_a_c        = 2'b10;
        src_b_c        = 2'b01;
        pc_write_c     = 1'b1;
        pc_source_c    = 1'b1;
        is_immediate_c = (state_q == JALR_CALC);
        state_d        = (state_q == JAL_CALC) ? JAL_WB : JALR_WB;
      end
      AUIPC_CALC: begin
        src_a_c = 2'b10;
        src_b_c = 2'b10;
        state_d = AUIPC_WB;
      end
      LUI_CALC: begin
        src_a_c = 2'b11;
        src_b_c = 2'b10;
        state_d = LUI_WB;
      end
      ALUWB, JAL_WB, JALR_WB, AUIPC_WB, LUI_WB: begin
        reg_write_c = 1'b1;
        retired_c   = 1'b1;
        state_d     = FETCH;
      end
      TRAP:    halted_c = 1'b1;
      default: state_d  = FETCH;
    endcase

    // A ready in the same cycle wins, since timeout already requires !mem_ready.
    if (timeout) begin
      state_d = TRAP;
      cause_d = 2'b11;
    end

    instret_d = instret_q + CNT_W'(retired_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      cause_q   <= 2'b00;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  assign bus.pc_write      = pc_write_c;
  assign bus.ir_write      = ir_write_c;
  assign bus.pc_source     = pc_source_c;
  assign bus.reg_write     = reg_write_c;
  assign bus.memory_read   = memory_read_c;
  assign bus.is_immediate  = is_immediate_c;
  assign bus.memory_write  = memory_write_c && (state_q == MEMWRITE);
  assign bus.pc_write_cond = pc_write_cond_c;
  assign bus.lorD          = lord_c;
  assign bus.memory_to_reg = mem_to_reg_c;
  assign bus.aluop         = aluop_c;
  assign bus.alu_src_a     = src_a_c;
  assign bus.alu_src_b     = src_b_c;
  assign bus.halted        = halted_c;
  assign bus.trap_cause    = cause_q;
  assign bus.retired       = retired_c;
  assign bus.instret       = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl_wait.sv
// Two controller configurations driven by shared stimulus, each checked every
// cycle against a phase-queue model of the instruction sequencing rules.
module tb_multicycle_ctrl_wait;
  logic       clk;
  logic       rst;
  logic       mem_ready;
  logic [6:0] opcode;
  int         n_cmp;
  int         n_fail;

  // Model phases; every write-back flavour collapses into PH_WB.
  localparam int PH_FETCH = 0, PH_DEC = 1, PH_ADR = 2, PH_RD = 3, PH_MWB = 4,
                 PH_WR = 5, PH_EXR = 6, PH_EXI = 7, PH_WB = 8, PH_BR = 9,
                 PH_JC = 10, PH_JRC = 11, PH_UC = 12, PH_LC = 13, PH_TRAP = 14;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bits: pcw irw psrc rw mr imm mw pwc lorD m2r aluop[2] a[2] b[2]
  function automatic logic [15:0] exp_ctrl(input int ph, input logic rdy);
    logic [15:0] c;
    c = '0;
    case (ph)
      PH_FETCH: begin c[11] = 1'b1; c[1:0] = 2'b01; c[15] = rdy; c[14] = rdy; end
      PH_DEC:   begin c[3:2] = 2'b10; c[1:0] = 2'b10; end
      PH_ADR:   begin c[3:2] = 2'b01; c[1:0] = 2'b10; end
      PH_RD:    begin c[11] = 1'b1; c[7] = 1'b1; end
      PH_MWB:   begin c[12] = 1'b1; c[6] = 1'b1; end
      PH_WR:    begin c[9] = 1'b1; c[7] = 1'b1; end
      PH_EXR:   begin c[3:2] = 2'b01; c[5:4] = 2'b10; end
      PH_EXI:   begin c[3:2] = 2'b01; c[1:0] = 2'b10; c[5:4] = 2'b10; c[10] = 1'b1; end
      PH_WB:    c[12] = 1'b1;
      PH_BR:    begin c[3:2] = 2'b01; c[5:4] = 2'b01; c[8] = 1'b1; c[13] = 1'b1; end
      PH_JC:    begin c[3:2] = 2'b10; c[1:0] = 2'b01; c[15] = 1'b1; c[13] = 1'b1; end
      PH_JRC:   begin c[3:2] = 2'b10; c[1:0] = 2'b01; c[15] = 1'b1; c[13] = 1'b1; c[10] = 1'b1; end
      PH_UC:    begin c[3:2] = 2'b10; c[1:0] = 2'b10; end
      PH_LC:    begin c[3:2] = 2'b11; c[1:0] = 2'b10; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int TO = (g == 0) ? 4 : 16;
    localparam int CW = (g == 0) ? 32 : 8;
    localparam int SU = (g == 0) ? 1 : 0;

    multicycle_ctrl_wait_if #(.CNT_W(CW)) bus ();
    assign bus.mem_ready          = mem_ready;
    assign bus.instruction_opcode = opcode;

    multicycle_ctrl_wait #(.MEM_TIMEOUT(TO), .CNT_W(CW), .SUPPORT_UPPER(SU)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    int          m_q[$];
    int          m_cause;
    int          m_instret;
    int          m_wait;
    int          mw_tot;
    int          irw_tot;
    int          ph;
    logic        exp_ret;
    logic [15:0] act_c;
    logic [CW-1:0] exp_i;

    initial begin
      mw_tot  = 0;
      irw_tot = 0;
    end

    always @(negedge clk) begin
      if (rst) begin
        m_q.delete();
        m_q.push_back(PH_FETCH);
        m_cause   = 0;
        m_instret = 0;
        m_wait    = 0;
      end
      if (m_q.size() != 0) begin
        ph      = m_q[0];
        exp_ret = (ph == PH_MWB) || (ph == PH_WB) || (ph == PH_BR) ||
                  ((ph == PH_WR) && mem_ready);
        act_c = {bus.pc_write, bus.ir_write, bus.pc_source, bus.reg_write,
                 bus.memory_read, bus.is_immediate, bus.memory_write,
                 bus.pc_write_cond, bus.lorD, bus.memory_to_reg,
                 bus.aluop, bus.alu_src_a, bus.alu_src_b};
        exp_i = CW'(m_instret);
        chk($sformatf("dut%0d.ctrl", g), 32'(act_c), 32'(exp_ctrl(ph, mem_ready)));
        chk($sformatf("dut%0d.halted", g), 32'(bus.halted), 32'(ph == PH_TRAP));
        chk($sformatf("dut%0d.trap_cause", g), 32'(bus.trap_cause), 32'(m_cause));
        chk($sformatf("dut%0d.retired", g), 32'(bus.retired), 32'(exp_ret));
        chk($sformatf("dut%0d.instret", g), 32'(bus.instret), 32'(exp_i));
        mw_tot  += int'(bus.memory_write);
        irw_tot += int'(bus.ir_write);

        if (!rst) begin
          if (exp_ret) m_instret++;
          case (ph)
            PH_TRAP: ;
            PH_FETCH, PH_RD, PH_WR: begin
              if (mem_ready) begin
                m_wait = 0;
                void'(m_q.pop_front());
                if (ph == PH_FETCH) m_q.push_back(PH_DEC);
              end else begin
                m_wait++;
                if (TO != 0 && m_wait >= TO) begin
                  m_q.delete();
                  m_q.push_back(PH_TRAP);
                  m_cause = 3;
                end
              end
            end
            PH_DEC: begin
              void'(m_q.pop_front());
              case (opcode)
                7'h03, 7'h23: m_q.push_back(PH_ADR);
                7'h33: begin m_q.push_back(PH_EXR); m_q.push_back(PH_WB); end
                7'h13: begin m_q.push_back(PH_EXI); m_q.push_back(PH_WB); end
                7'h63: m_q.push_back(PH_BR);
                7'h6F: begin m_q.push_back(PH_JC); m_q.push_back(PH_WB); end
                7'h67: begin m_q.push_back(PH_JRC); m_q.push_back(PH_WB); end
                7'h17: if (SU != 0) begin m_q.push_back(PH_UC); m_q.push_back(PH_WB); end
                       else begin m_q.push_back(PH_TRAP); m_cause = 1; end
                7'h37: if (SU != 0) begin m_q.push_back(PH_LC); m_q.push_back(PH_WB); end
                       else begin m_q.push_back(PH_TRAP); m_cause = 1; end
                7'h73: begin m_q.push_back(PH_TRAP); m_cause = 2; end
                default: begin m_q.push_back(PH_TRAP); m_cause = 1; end
              endcase
            end
            PH_ADR: begin
              void'(m_q.pop_front());
              if (opcode == 7'h03) begin
                m_q.push_back(PH_RD);
                m_q.push_back(PH_MWB);
              end else begin
                m_q.push_back(PH_WR);
              end
            end
            default: void'(m_q.pop_front());
          endcase
          if (m_q.size() == 0) m_q.push_back(PH_FETCH);
        end
      end
    end
  end

  task automatic cyc(input logic rdy, input logic [6:0] op, input int n);
    mem_ready = rdy;
    opcode    = op;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [6:0] ops [10];
  initial begin
    int snap_mw;
    int snap_irw;
    int stall;
    int idx;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h17, 7'h37, 7'h73};
    n_cmp     = 0;
    n_fail    = 0;
    stall     = 0;
    rst       = 1'b1;
    mem_ready = 1'b0;
    opcode    = 7'h00;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    chk("reset.instret", g_dut[0].bus.instret, 32'd0);
    chk("reset.halted", 32'(g_dut[0].bus.halted), 32'd0);
    chk("reset.trap_cause", 32'(g_dut[0].bus.trap_cause), 32'd0);
    chk("reset.memory_read", 32'(g_dut[0].bus.memory_read), 32'd1);

    // R-type then load, no waits
    cyc(1'b1, 7'h33, 4);
    cyc(1'b1, 7'h03, 5);
    chk("rl.instret0", g_dut[0].bus.instret, 32'd2);
    chk("rl.instret1", 32'(g_dut[1].bus.instret), 32'd2);

    // store with three wait cycles in MEMWRITE
    snap_mw = g_dut[1].mw_tot;
    cyc(1'b1, 7'h23, 3);
    cyc(1'b0, 7'h23, 3);
    cyc(1'b1, 7'h23, 1);
    chk("st.mw_cycles", 32'(g_dut[1].mw_tot - snap_mw), 32'd4);
    chk("st.instret", g_dut[0].bus.instret, 32'd3);
    chk("st.halted", 32'(g_dut[0].bus.halted), 32'd0);

    // fetch timeout at MEM_TIMEOUT=4
    snap_irw = g_dut[0].irw_tot;
    cyc(1'b0, 7'h33, 4);
    chk("to.halted", 32'(g_dut[0].bus.halted), 32'd1);
    chk("to.trap_cause", 32'(g_dut[0].bus.trap_cause), 32'd3);
    chk("to.ir_write_seen", 32'(g_dut[0].irw_tot - snap_irw), 32'd0);
    chk("to.dut1_running", 32'(g_dut[1].bus.halted), 32'd0);
    do_reset();
    cyc(1'b0, 7'h33, 3);
    cyc(1'b1, 7'h33, 1);
    chk("to_edge.halted", 32'(g_dut[0].bus.halted), 32'd0);
    chk("to_edge.decode_a", 32'(g_dut[0].bus.alu_src_a), 32'd2);
    cyc(1'b1, 7'h33, 3);

    // illegal and SYSTEM traps, held 20 cycles
    cyc(1'b1, 7'h7F, 2);
    chk("ill.trap_cause", 32'(g_dut[0].bus.trap_cause), 32'd1);
    cyc(1'b1, 7'h33, 20);
    chk("ill.halted", 32'(g_dut[0].bus.halted), 32'd1);
    do_reset();
    chk("trap_rst.trap_cause", 32'(g_dut[0].bus.trap_cause), 32'd0);
    chk("trap_rst.instret", g_dut[0].bus.instret, 32'd0);
    cyc(1'b1, 7'h73, 2);
    chk("sys.trap_cause", 32'(g_dut[1].bus.trap_cause), 32'd2);
    cyc(1'b0, 7'h13, 20);
    do_reset();

    // LUI with and without upper support
    cyc(1'b1, 7'h37, 2);
    chk("lui.a", 32'(g_dut[0].bus.alu_src_a), 32'd3);
    chk("lui.b", 32'(g_dut[0].bus.alu_src_b), 32'd2);
    chk("lui.illegal", 32'(g_dut[1].bus.trap_cause), 32'd1);
    cyc(1'b1, 7'h37, 1);
    chk("lui.reg_write", 32'(g_dut[0].bus.reg_write), 32'd1);
    cyc(1'b1, 7'h37, 1);
    do_reset();

    // reset during JALR_CALC
    cyc(1'b1, 7'h33, 4);
    cyc(1'b1, 7'h67, 2);
    chk("jalr.pc_write", 32'(g_dut[0].bus.pc_write), 32'd1);
    chk("jalr.is_immediate", 32'(g_dut[0].bus.is_immediate), 32'd1);
    rst = 1'b1;
    #1;
    chk("jalr_rst.instret", g_dut[0].bus.instret, 32'd0);
    chk("jalr_rst.pc_write_hi", 32'(g_dut[0].bus.pc_write), 32'd1);
    mem_ready = 1'b0;
    #1;
    chk("jalr_rst.pc_write_lo", 32'(g_dut[0].bus.pc_write), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, 39);
        if (idx < 36)      opcode = ops[idx % 9];
        else if (idx < 38) opcode = ops[9];
        else               opcode = 7'($urandom_range(0, 127));
      end
      if (stall > 0) begin
        mem_ready = 1'b0;
        stall--;
      end else begin
        if ($urandom_range(0, 79) == 0) stall = 6;
        mem_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
